// File: rtl/right_shift_tx_pkg.sv
// Shared definitions for the right-shift serial transmitter and its left-shift builder peer.
package right_shift_tx_pkg;

  // Word size agreed between the serial builder and this transmitter
  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/right_shift_tx_shift_reg.sv
// right_shift_reg: WIDTH-bit register with async clear, parallel load and
// zero-filling shift toward bit 0.
module right_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr)        r_q <= '0;
    else if (i_load)  r_q <= i_data;
    else if (i_shift) r_q <= {1'b0, r_q[WIDTH-1:1]};
  end

  assign o_q   = r_q;
  assign o_lsb = r_q[0];

endmodule

// File: rtl/right_shift_tx.sv
// Parallel-in, LSB-first serial transmitter with done pulse.
// Define RIGHT_SHIFT_TX_PARITY_EN to append an even-parity bit to each frame.
module right_shift_tx
  import right_shift_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic [WIDTH-1:0] number
);

  localparam int CW = $clog2(WIDTH);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_load, w_shift, w_last, w_lsb;

  right_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (data),
    .o_q     (number),
    .o_lsb   (w_lsb)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: if (load) begin
        w_load = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
`ifdef RIGHT_SHIFT_TX_PARITY_EN
        if (w_last) w_next = ST_PAR;
`else
        if (w_last) w_next = ST_DONE;
`endif
      end
`ifdef RIGHT_SHIFT_TX_PARITY_EN
      ST_PAR:  w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Counter stops at WIDTH-1 so it cannot wrap when WIDTH is a power of two
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                    r_cnt <= '0;
    else if (w_load)            r_cnt <= '0;
    else if (w_shift && !w_last) r_cnt <= r_cnt + CW'(1);
  end

`ifdef RIGHT_SHIFT_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)          r_par <= 1'b0;
    else if (w_load)  r_par <= 1'b0;
    else if (w_shift) r_par <= r_par ^ w_lsb;
  end
`endif

  always_comb begin
    ready      = (r_state == ST_IDLE);
    done       = (r_state == ST_DONE);
    sout_valid = 1'b0;
    sout       = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        sout_valid = 1'b1;
        sout       = w_lsb;
      end
`ifdef RIGHT_SHIFT_TX_PARITY_EN
      ST_PAR: begin
        sout_valid = 1'b1;
        sout       = r_par;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_right_shift_tx.sv
// Bench for right_shift_tx: frame-position model checked every cycle plus directed literal checks.
module tb_right_shift_tx;
  import right_shift_tx_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef RIGHT_SHIFT_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? W + 1 : W;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic         ready, sout, sout_valid, done;
  logic [W-1:0] number;

  right_shift_tx #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .load(load), .data(data),
    .ready(ready), .sout(sout), .sout_valid(sout_valid), .done(done), .number(number)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the current frame (-1 = idle); FRAME is the done cycle
  int           m_pos = -1;
  logic [W-1:0] m_word = '0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_pos  <= -1;
      m_word <= '0;
    end else if (m_pos < 0) begin
      if (load) begin
        m_pos  <= 0;
        m_word <= data;
      end
    end else if (m_pos == FRAME) m_pos <= -1;
    else m_pos <= m_pos + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [W-1:0] en;
      logic         es;
      es = 1'b0;
      en = '0;
      if (m_pos >= 0 && m_pos < W) begin
        es = m_word[m_pos];
        en = m_word >> m_pos;
      end else if (PAR && m_pos == W) es = ^m_word;
      chk("ready", 32'(ready), 32'(m_pos < 0));
      chk("sout_valid", 32'(sout_valid), 32'(m_pos >= 0 && m_pos < FRAME));
      chk("done", 32'(done), 32'(m_pos == FRAME));
      chk("sout", 32'(sout), 32'(es));
      chk("number", 32'(number), 32'(en));
    end
  end

  // Capture of transmitted bits and done pulses for directed checks
  bit cap_q[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (sout_valid) cap_q.push_back(sout);
    if (done) done_cnt++;
  end

  function automatic logic [W-1:0] packq(input int off);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++)
      if (off + i < cap_q.size()) v[i] = cap_q[off + i];
    return v;
  endfunction

  task automatic send(input logic [W-1:0] w);
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    load = 1'b1;
    data = w;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_reached_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int ones, gap, idx;
    bit v[64];

    // Reset and idle
    #1 clr = 1'b1;
    #1 chk_on = 1'b1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_number", 32'(number), 32'd0);
    chk("rst_valid", 32'(sout_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #9 clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_number", 32'(number), 32'd0);

    // Basic transfer
    send(6'b101101);
    wait_done("basic", n);
    chk("basic_latency", 32'(n), PAR ? 32'd7 : 32'd6);
    chk("basic_number_at_done", 32'(number), 32'd0);
    @(negedge clk);
    chk("basic_ready_after", 32'(ready), 32'd1);
    chk("basic_nbits", 32'(cap_q.size()), 32'(FRAME));
    chk("basic_bits", 32'(packq(0)), 32'b101101);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

`ifdef RIGHT_SHIFT_TX_PARITY_EN
    send(6'b000111);
    wait_done("par1", n);
    chk("par1_latency", 32'(n), 32'd7);
    chk("par1_bits", 32'(packq(0)), 32'b000111);
    chk("par1_parity", 32'(cap_q[6]), 32'd1);
    send(6'b000011);
    wait_done("par0", n);
    chk("par0_bits", 32'(packq(0)), 32'b000011);
    chk("par0_parity", 32'(cap_q[6]), 32'd0);
`endif

    // Load while busy is ignored
    send(6'b111111);
    @(negedge clk);
    @(negedge clk);
    load = 1'b1;
    data = 6'b000000;
    @(negedge clk);
    load = 1'b0;
    wait_done("busy", n);
    repeat (FRAME + 3) @(negedge clk);
    chk("busy_nbits", 32'(cap_q.size()), 32'(FRAME));
    chk("busy_bits", 32'(packq(0)), 32'b111111);
    chk("busy_done_cnt", 32'(done_cnt), 32'd1);
    chk("busy_idle", 32'(ready), 32'd1);

    // Reset during the 4th shift cycle
    send(6'b110011);
    repeat (3) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_valid", 32'(sout_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_number", 32'(number), 32'd0);
    load = 1'b1;
    data = 6'b010101;
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    cap_q.delete();
    clr = 1'b0;
    @(negedge clk);
    load = 1'b0;
    wait_done("post_abort", n);
    chk("post_abort_latency", 32'(n), PAR ? 32'd7 : 32'd6);
    chk("post_abort_bits", 32'(packq(0)), 32'b010101);

    // Back-to-back with load held high
    @(negedge clk);
    cap_q.delete();
    done_cnt = 0;
    load = 1'b1;
    data = 6'b100000;
    for (int i = 0; i < 2 * (FRAME + 2); i++) begin
      @(negedge clk);
      v[i] = sout_valid;
      if (i == 2 * (FRAME + 2) - 1) load = 1'b0;
    end
    ones = 0;
    while (ones < 64 && v[ones]) ones++;
    gap = 0;
    idx = ones;
    while (idx < 2 * (FRAME + 2) && !v[idx]) begin
      gap++;
      idx++;
    end
    chk("b2b_frame_len", 32'(ones), PAR ? 32'd7 : 32'd6);
    chk("b2b_gap", 32'(gap), 32'd2);
    repeat (3) @(negedge clk);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
    chk("b2b_nbits", 32'(cap_q.size()), 32'(2 * FRAME));
    chk("b2b_bits0", 32'(packq(0)), 32'b100000);
    chk("b2b_bits1", 32'(packq(FRAME)), 32'b100000);
    chk("b2b_idle", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
